// File: rtl/cgp_fitness_evaluator_if.sv
// Bus between the evolution controller / candidate and the fitness evaluator.
// The evaluator is the slave. The master side drives start and the candidate
// response, and observes the stimulus vector and the published score.
interface cgp_fitness_evaluator_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int CNT_W = $clog2((2**IN_W)*OUT_W+1)
);
    logic             start;
    logic [IN_W-1:0]  cand_in;
    logic [OUT_W-1:0] cand_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             trivial;

    modport master (
        output start,
        output cand_out,
        input  cand_in,
        input  busy,
        input  done,
        input  match_cnt,
        input  mismatch_cnt,
        input  trivial
    );

    modport slave (
        input  start,
        input  cand_out,
        output cand_in,
        output busy,
        output done,
        output match_cnt,
        output mismatch_cnt,
        output trivial
    );
endinterface

// File: rtl/cgp_fitness_evaluator.sv
// Fitness scorer for an evolved 2-bit + 2-bit adder candidate.
// It sweeps every input vector and holds each one long enough for the
// candidate to settle. It then samples the response and accumulates the
// Hamming distance to the golden sum. Results are published together with a
// one-cycle done pulse and stay stable until the next sweep completes.
module cgp_fitness_evaluator #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = $clog2((2**IN_W)*OUT_W+1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cgp_fitness_evaluator_if.slave       bus
);

    localparam int HALF  = IN_W / 2;
    localparam int TOTAL = (2**IN_W) * OUT_W;
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // HOLD lasts SETTLE-1 cycles, so a vector spends DRIVE + HOLD + SAMPLE =
    // SETTLE+1 cycles in total. The counter counts down to zero.
    localparam logic [SW-1:0]    HOLD_LOAD = (SETTLE > 1) ? SW'(SETTLE - 2) : '0;
    localparam logic [IN_W-1:0]  VEC_LAST  = '1;
    localparam logic [CNT_W-1:0] TRIV_CNT  = CNT_W'(TOTAL / 2);
    localparam logic [CNT_W-1:0] OUT_W_CNT = CNT_W'(OUT_W);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_PUBLISH = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Golden response: A + B, zero-extended to the output width.
    function automatic logic [OUT_W-1:0] golden_sum(input logic [IN_W-1:0] v);
        golden_sum = OUT_W'(v[HALF-1:0]) + OUT_W'(v[IN_W-1:HALF]);
    endfunction

    // Number of differing bits. Case inequality makes X/Z count as a miss.
    function automatic logic [CNT_W-1:0] miss_bits(input logic [OUT_W-1:0] got,
                                                   input logic [OUT_W-1:0] gold);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_W; i++) begin
            n = n + CNT_W'(got[i] !== gold[i]);
        end
        return n;
    endfunction

    state_e           state_q,        state_d;
    logic [IN_W-1:0]  vec_q,          vec_d;
    logic [SW-1:0]    cnt_q,          cnt_d;
    logic [CNT_W-1:0] match_acc_q,    match_acc_d;
    logic [CNT_W-1:0] mis_acc_q,      mis_acc_d;
    logic [IN_W-1:0]  cand_in_q,      cand_in_d;
    logic             busy_q,         busy_d;
    logic             done_q,         done_d;
    logic [CNT_W-1:0] match_cnt_q,    match_cnt_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic             trivial_q,      trivial_d;
    logic [CNT_W-1:0] sample_miss_s;

    assign sample_miss_s = miss_bits(bus.cand_out, golden_sum(vec_q));

    // State register and all datapath/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            vec_q          <= '0;
            cnt_q          <= '0;
            match_acc_q    <= '0;
            mis_acc_q      <= '0;
            cand_in_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            trivial_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            cnt_q          <= cnt_d;
            match_acc_q    <= match_acc_d;
            mis_acc_q      <= mis_acc_d;
            cand_in_q      <= cand_in_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            trivial_q      <= trivial_d;
        end
    end

    // Next-state and next-value logic for the sweep sequencer.
    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        cnt_d          = cnt_q;
        match_acc_d    = match_acc_q;
        mis_acc_d      = mis_acc_q;
        cand_in_d      = cand_in_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        trivial_d      = trivial_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_DRIVE;
                    vec_d       = '0;
                    match_acc_d = '0;
                    mis_acc_d   = '0;
                    busy_d      = 1'b1;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_DRIVE: begin
                cand_in_d = vec_q;
                cnt_d     = HOLD_LOAD;
                if (SETTLE > 1) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d   = cnt_q - SW'(1);
                end
            end
            ST_SAMPLE: begin
                mis_acc_d   = mis_acc_q + sample_miss_s;
                match_acc_d = match_acc_q + (OUT_W_CNT - sample_miss_s);
                if (vec_q == VEC_LAST) begin
                    state_d = ST_PUBLISH;
                end else begin
                    vec_d   = vec_q + IN_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_PUBLISH: begin
                // Results are published one cycle after the last sample has
                // been folded into the accumulators.
                match_cnt_d    = match_acc_q;
                mismatch_cnt_d = mis_acc_q;
                trivial_d      = (mis_acc_q == TRIV_CNT);
                done_d         = 1'b1;
                busy_d         = 1'b0;
                state_d        = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cand_in      = cand_in_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.match_cnt    = match_cnt_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
    assign bus.trivial      = trivial_q;

endmodule

// File: tb/tb_cgp_fitness_evaluator.sv
// Scoreboard bench for cgp_fitness_evaluator: a driver issues sweeps against
// a modelled candidate and pushes the expected score; a monitor checks done
// timing, published counts, held results, busy and the vector sequence.
module tb_cgp_fitness_evaluator;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 4;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 7;
    localparam int NVEC   = 16;
    localparam int TOTAL  = 64;
    localparam int LAT    = 49;
    localparam int SPAN   = 48;

    typedef struct {
        int     match;
        int     mis;
        int     triv;
        longint cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cgp_fitness_evaluator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    cgp_fitness_evaluator #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc   = 0;
    int         mode  = 0;
    logic [3:0] lut [NVEC];
    exp_t       sb [$];
    bit         active = 1'b0;
    longint     k      = 0;
    int         last_match = 0;
    int         last_mis   = 0;
    int         last_triv  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Candidate under evaluation: selectable behaviours.
    always_comb begin
        case (mode)
            0:       bus.cand_out = {2'b00, bus.cand_in[1:0]} + {2'b00, bus.cand_in[3:2]};
            1:       bus.cand_out = 4'b0000;
            2:       bus.cand_out = 4'b1111;
            3:       bus.cand_out = ({2'b00, bus.cand_in[1:0]} + {2'b00, bus.cand_in[3:2]}) ^ 4'b0011;
            default: bus.cand_out = lut[bus.cand_in];
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference score: count wrong output bits over all A,B pairs.
    function automatic exp_t ref_sweep(input int m);
        exp_t e;
        int   a, b, gold, resp, mis;
        mis = 0;
        for (int v = 0; v < NVEC; v++) begin
            a    = v % 4;
            b    = v / 4;
            gold = a + b;
            case (m)
                0:       resp = gold;
                1:       resp = 0;
                2:       resp = 15;
                3:       resp = gold ^ 3;
                default: resp = int'(lut[v]);
            endcase
            mis += $countones(4'(resp ^ gold));
        end
        e.mis   = mis;
        e.match = TOTAL - mis;
        e.triv  = (mis == TOTAL / 2) ? 1 : 0;
        e.cyc   = 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue();
        exp_t e;
        e     = ref_sweep(mode);
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
        k      = cyc + 1;
        active = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (bus.done) break;
            step();
        end
        if (!bus.done) check("done_timeout", bus.done, 1);
    endtask

    task automatic stray_start(input int off);
        while (cyc < k + off) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        sb.delete();
        active     = 1'b0;
        last_match = 0;
        last_mis   = 0;
        last_triv  = 0;
        repeat (cycles) step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: checks outputs on the falling edge against the scoreboard.
    always @(negedge clk) begin
        longint o;
        exp_t   e;
        if (!rst_n) begin
            check("rst_cand_in", bus.cand_in, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_match", bus.match_cnt, 0);
            check("rst_mismatch", bus.mismatch_cnt, 0);
            check("rst_trivial", bus.trivial, 0);
        end else begin
            o = cyc - k;
            check("busy", bus.busy, (active && o >= 0 && o <= SPAN) ? 1 : 0);
            if (active && o >= 1 && o <= SPAN)
                check("cand_in", bus.cand_in, (o - 1) / (SETTLE + 1));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("match_cnt", bus.match_cnt, e.match);
                    check("mismatch_cnt", bus.mismatch_cnt, e.mis);
                    check("trivial", bus.trivial, e.triv);
                    check("invariant", bus.match_cnt + bus.mismatch_cnt, TOTAL);
                    last_match = e.match;
                    last_mis   = e.mis;
                    last_triv  = e.triv;
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    check("done_missing", bus.done, 1);
                    void'(sb.pop_front());
                end
                check("held_match", bus.match_cnt, last_match);
                check("held_mismatch", bus.mismatch_cnt, last_mis);
                check("held_trivial", bus.trivial, last_triv);
            end
        end
    end

    // Driver: directed scenarios followed by randomized sweeps.
    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < NVEC; i++) lut[i] = 4'($urandom_range(0, 15));
        #1 rst_n = 1'b0;
        do_reset(3);

        for (int m = 0; m < 4; m++) begin
            mode = m;
            issue();
            wait_done();
            repeat ($urandom_range(1, 3)) step();
        end

        mode = 0;
        issue();
        stray_start(9);
        stray_start(29);
        wait_done();
        step();

        mode = 2;
        issue();
        while (cyc < k + 19) step();
        do_reset(3);
        issue();
        wait_done();
        step();

        mode = 0;
        issue();
        wait_done();
        mode = 1;
        issue();
        wait_done();
        step();

        for (int r = 0; r < 12; r++) begin
            mode = $urandom_range(0, 4);
            if (mode == 4)
                for (int i = 0; i < NVEC; i++) lut[i] = 4'($urandom_range(0, 15));
            issue();
            if ($urandom_range(0, 1) == 1) stray_start($urandom_range(0, 47));
            wait_done();
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 4)) step();
        end

        for (int i = 0; i < 200 && sb.size() > 0; i++) step();
        check("drain", sb.size(), 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
